// File: rtl/ddr3_cmd_seq.sv
// Closed-page DDR3 command sequencer: one request -> ACT, tRCD gap, READ/WRITE with auto-precharge, tRC gap.
// Latency: ACT is presented the clock after acceptance; the column command follows TRCD_CYCLES clocks after the ACT handshake.
// Backpressure: commands are held stable until ctl_rdy_i; req_ready_o is high only while idle with no refresh due.
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   req_valid_i/req_ready_o upstream request handshake
//   req_write_i, req_addr_i request direction and word address {row, bank[2:0], col}
//   ctl_req_o/ctl_rdy_i     command handshake towards ddr3_ddl
//   ctl_seq_o               high on ACT (a column command follows)
//   ctl_cmd_o/ba_o/adr_o    command code, bank, row or column address (A10 = auto-precharge)
// Optional feature: DDR3_CMD_SEQ_REFRESH_EN enables periodic REF every TREFI_CYCLES clocks.
module ddr3_cmd_seq #(
  parameter int DDR_ROW_BITS = 13,
  parameter int DDR_COL_BITS = 10,
  parameter int TRCD_CYCLES  = 2,
  parameter int TRC_CYCLES   = 6,
  parameter int TRFC_CYCLES  = 16,
  parameter int TREFI_CYCLES = 780
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  input  logic                                 req_write_i,
  input  logic [DDR_ROW_BITS+DDR_COL_BITS+2:0] req_addr_i,
  output logic                                 ctl_req_o,
  output logic                                 ctl_seq_o,
  input  logic                                 ctl_rdy_i,
  output logic [2:0]                           ctl_cmd_o,
  output logic [2:0]                           ctl_ba_o,
  output logic [DDR_ROW_BITS-1:0]              ctl_adr_o
);

  localparam logic [2:0] CMD_NOP   = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b010;
  localparam logic [2:0] CMD_ACT   = 3'b011;
  localparam logic [2:0] CMD_WRITE = 3'b100;

  // A zero delay parameter still costs one clock in the wait state.
  localparam int TRCD_E  = (TRCD_CYCLES < 1) ? 1 : TRCD_CYCLES;
  localparam int TRC_E   = (TRC_CYCLES  < 1) ? 1 : TRC_CYCLES;
  localparam int TRFC_E  = (TRFC_CYCLES < 1) ? 1 : TRFC_CYCLES;
  localparam int DLY_A   = (TRCD_E > TRC_E) ? TRCD_E : TRC_E;
  localparam int DLY_MAX = (DLY_A > TRFC_E) ? DLY_A : TRFC_E;
  // Counter is loaded with delay-1 and counts down to 0.
  localparam int CNT_W   = (DLY_MAX < 2) ? 1 : $clog2(DLY_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_ACT, S_TRCD, S_COL, S_TRC, S_REF, S_TRFC
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    write_q, write_d;
  logic [2:0]              bank_q, bank_d;
  logic [DDR_ROW_BITS-1:0] row_q, row_d;
  logic [DDR_COL_BITS-1:0] col_q, col_d;
  logic [DDR_ROW_BITS-1:0] col_adr;
  logic                    ref_hold;

`ifdef DDR3_CMD_SEQ_REFRESH_EN
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam int TREFI_E = (TREFI_CYCLES < 1) ? 1 : TREFI_CYCLES;
  localparam int REFI_W  = (TREFI_E < 2) ? 1 : $clog2(TREFI_E);

  logic [REFI_W-1:0] refi_q, refi_d;
  logic              ref_pend_q, ref_pend_d;
  logic              ref_due;
  logic              pend_clr;

  // Free-running interval counter; several elapsed intervals collapse into one pending flag.
  assign ref_due  = (refi_q == REFI_W'(TREFI_E - 1));
  assign refi_d   = ref_due ? '0 : refi_q + REFI_W'(1);
  // A refresh falling due this very clock already blocks new requests.
  assign ref_hold = ref_pend_q | ref_due;

  always_comb begin
    ref_pend_d = (ref_pend_q & ~pend_clr) | ref_due;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      refi_q     <= '0;
      ref_pend_q <= 1'b0;
    end else begin
      refi_q     <= refi_d;
      ref_pend_q <= ref_pend_d;
    end
  end
`else
  assign ref_hold = 1'b0;
  // Refresh interval only matters when refresh is compiled in.
  if (TREFI_CYCLES > 0) begin : g_refi_unused
  end
`endif

  // Column address with A10 forced high for auto-precharge.
  always_comb begin
    col_adr                     = '0;
    col_adr[DDR_COL_BITS-1:0]   = col_q;
    col_adr[10]                 = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    bank_d      = bank_q;
    row_d       = row_q;
    col_d       = col_q;
    req_ready_o = 1'b0;
    ctl_req_o   = 1'b0;
    ctl_seq_o   = 1'b0;
    ctl_cmd_o   = CMD_NOP;
    ctl_ba_o    = '0;
    ctl_adr_o   = '0;
`ifdef DDR3_CMD_SEQ_REFRESH_EN
    pend_clr    = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        req_ready_o = ~reset & ~ref_hold;
`ifdef DDR3_CMD_SEQ_REFRESH_EN
        if (ref_hold) begin
          state_d = S_REF;
        end
`endif
        if (req_valid_i && req_ready_o) begin
          write_d = req_write_i;
          col_d   = req_addr_i[DDR_COL_BITS-1:0];
          bank_d  = req_addr_i[DDR_COL_BITS+2:DDR_COL_BITS];
          row_d   = req_addr_i[DDR_ROW_BITS+DDR_COL_BITS+2:DDR_COL_BITS+3];
          state_d = S_ACT;
        end
      end
      S_ACT: begin
        ctl_req_o = 1'b1;
        ctl_seq_o = 1'b1;
        ctl_cmd_o = CMD_ACT;
        ctl_ba_o  = bank_q;
        ctl_adr_o = row_q;
        if (ctl_rdy_i) begin
          cnt_d   = CNT_W'(TRCD_E - 1);
          state_d = S_TRCD;
        end
      end
      S_TRCD: begin
        if (cnt_q == '0) state_d = S_COL;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_COL: begin
        ctl_req_o = 1'b1;
        ctl_cmd_o = write_q ? CMD_WRITE : CMD_READ;
        ctl_ba_o  = bank_q;
        ctl_adr_o = col_adr;
        if (ctl_rdy_i) begin
          cnt_d   = CNT_W'(TRC_E - 1);
          state_d = S_TRC;
        end
      end
      S_TRC: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
`ifdef DDR3_CMD_SEQ_REFRESH_EN
      S_REF: begin
        ctl_req_o = 1'b1;
        ctl_cmd_o = CMD_REF;
        if (ctl_rdy_i) begin
          cnt_d   = CNT_W'(TRFC_E - 1);
          state_d = S_TRFC;
        end
      end
      S_TRFC: begin
        if (cnt_q == '0) begin
          pend_clr = 1'b1;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Reset discards any latched request so an aborted transaction never resumes.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      bank_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      bank_q  <= bank_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

endmodule

// File: tb/tb_ddr3_cmd_seq.sv
module tb_ddr3_cmd_seq;

  localparam logic [2:0] NOP = 3'b000, REF = 3'b001, RD = 3'b010, ACT = 3'b011, WR = 3'b100;

  logic        clock, reset;
  logic        req_valid_i, req_ready_o, req_write_i;
  logic [25:0] req_addr_i;
  logic        ctl_req_o, ctl_seq_o, ctl_rdy_i;
  logic [2:0]  ctl_cmd_o, ctl_ba_o;
  logic [12:0] ctl_adr_o;

  ddr3_cmd_seq #(
    .DDR_ROW_BITS(13), .DDR_COL_BITS(10), .TRCD_CYCLES(2), .TRC_CYCLES(6),
    .TRFC_CYCLES(16), .TREFI_CYCLES(20)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_write_i(req_write_i), .req_addr_i(req_addr_i),
    .ctl_req_o(ctl_req_o), .ctl_seq_o(ctl_seq_o), .ctl_rdy_i(ctl_rdy_i),
    .ctl_cmd_o(ctl_cmd_o), .ctl_ba_o(ctl_ba_o), .ctl_adr_o(ctl_adr_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Handshake monitor, sampled on the falling edge (inputs are stable until after the next rise).
  int cyc = 0;
  int n_act_hs = 0, n_write_hs = 0, n_read_hs = 0, n_ref_hs = 0;
  int act_cyc[$];
  int ref_cyc = -1;
  logic [12:0] last_col_adr = '0;

  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (!reset && ctl_req_o && ctl_rdy_i) begin
      case (ctl_cmd_o)
        ACT: begin n_act_hs++; act_cyc.push_back(cyc); end
        WR:  begin n_write_hs++; last_col_adr = ctl_adr_o; end
        RD:  n_read_hs++;
        REF: begin n_ref_hs++; ref_cyc = cyc; end
        default: ;
      endcase
    end
  end

  function automatic logic [25:0] mkaddr(input logic [12:0] row, input logic [2:0] ba,
                                         input logic [9:0] col);
    return {row, ba, col};
  endfunction

  typedef struct {
    logic        rst, vld, wr;
    logic [25:0] addr;
    logic        rdy;
    logic        e_rdy, e_req, e_seq;
    logic [2:0]  e_cmd, e_ba;
    logic [12:0] e_adr;
    string       name;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic rst, vld, wr, input logic [25:0] addr, input logic rdy,
                              input logic e_rdy, e_req, e_seq, input logic [2:0] e_cmd, e_ba,
                              input logic [12:0] e_adr, input string name);
    vec_t v;
    v.rst = rst; v.vld = vld; v.wr = wr; v.addr = addr; v.rdy = rdy;
    v.e_rdy = e_rdy; v.e_req = e_req; v.e_seq = e_seq;
    v.e_cmd = e_cmd; v.e_ba = e_ba; v.e_adr = e_adr; v.name = name;
    return v;
  endfunction

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (n < 40) begin
      @(negedge clock);
      if (req_ready_o) break;
      n++;
    end
    check(nm, (n < 40), 1);
    @(posedge clock); #1;
  endtask

  logic [25:0] addr_a, addr_b;

  initial begin
    reset = 1'b1; req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0; ctl_rdy_i = 1'b1;
    addr_a = mkaddr(13'd5, 3'd2, 10'h010);
    addr_b = mkaddr(13'h1ABC, 3'd7, 10'h3FF);

`ifdef DDR3_CMD_SEQ_REFRESH_EN
    begin : refresh_test
      int a0, n;
      logic accepted;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;            // this clock is interval count 0
      for (int k = 0; k < 19; k++) begin @(posedge clock); #1; end
      req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = addr_a;
      a0 = n_act_hs; accepted = 1'b0; n = 0;
      while (n_act_hs == a0 && n < 80) begin
        @(negedge clock);
        if (req_ready_o && req_valid_i) accepted = 1'b1;
        @(posedge clock); #1;
        if (accepted) req_valid_i = 1'b0;
        n++;
      end
      check("ref_act_seen", (n_act_hs == a0 + 1), 1);
      check("ref_count_before_act", n_ref_hs, 1);
      check("ref_to_act_ge16", ((act_cyc.size() > 0) && (ref_cyc >= 0) &&
                                (act_cyc[act_cyc.size()-1] - ref_cyc >= 16)), 1);
    end
`else
    // Cycle-by-cycle vectors: reset, closed-page read, then reset during TRCD.
    tv.push_back(mk(1,0,0,'0,1,     0,0,0,NOP,0,13'h0,"rst_0"));
    tv.push_back(mk(1,1,0,addr_a,1, 0,0,0,NOP,0,13'h0,"rst_1"));
    tv.push_back(mk(0,0,0,'0,1,     1,0,0,NOP,0,13'h0,"idle"));
    tv.push_back(mk(0,1,0,addr_a,1, 1,0,0,NOP,0,13'h0,"rd_accept"));
    tv.push_back(mk(0,0,0,'0,1,     0,1,1,ACT,2,13'h5,"rd_act"));
    tv.push_back(mk(0,0,0,'0,1,     0,0,0,NOP,0,13'h0,"rd_trcd0"));
    tv.push_back(mk(0,0,0,'0,1,     0,0,0,NOP,0,13'h0,"rd_trcd1"));
    tv.push_back(mk(0,0,0,'0,1,     0,1,0,RD,2,13'h410,"rd_col"));
    for (int i = 0; i < 6; i++)
      tv.push_back(mk(0,0,0,'0,1,   0,0,0,NOP,0,13'h0,"rd_trc"));
    tv.push_back(mk(0,0,0,'0,1,     1,0,0,NOP,0,13'h0,"rd_done"));
    tv.push_back(mk(0,1,1,addr_b,1, 1,0,0,NOP,0,13'h0,"wr_accept"));
    tv.push_back(mk(0,0,0,'0,1,     0,1,1,ACT,7,13'h1ABC,"wr_act"));
    tv.push_back(mk(1,0,0,'0,1,     0,0,0,NOP,0,13'h0,"rst_in_trcd"));
    for (int i = 0; i < 4; i++)
      tv.push_back(mk(0,0,0,'0,1,   1,0,0,NOP,0,13'h0,"post_abort"));

    foreach (tv[i]) begin
      @(posedge clock); #1;
      reset = tv[i].rst; req_valid_i = tv[i].vld; req_write_i = tv[i].wr;
      req_addr_i = tv[i].addr; ctl_rdy_i = tv[i].rdy;
      @(negedge clock);
      check(tv[i].name, {10'b0, req_ready_o, ctl_req_o, ctl_seq_o, ctl_cmd_o, ctl_ba_o, ctl_adr_o},
            {10'b0, tv[i].e_rdy, tv[i].e_req, tv[i].e_seq, tv[i].e_cmd, tv[i].e_ba, tv[i].e_adr});
    end
    check("abort_no_write", n_write_hs, 0);
    check("single_read", n_read_hs, 1);

    // Write with ACT backpressured for 4 clocks.
    begin : stall_test
      int w0;
      @(posedge clock); #1;
      req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = addr_b; ctl_rdy_i = 1'b0;
      @(negedge clock);
      check("stall_accept_ready", req_ready_o, 1);
      @(posedge clock); #1;
      req_valid_i = 1'b0;
      w0 = n_write_hs;
      for (int i = 0; i < 5; i++) begin
        ctl_rdy_i = (i == 4);
        @(negedge clock);
        check("stall_act_hold", {ctl_req_o, ctl_seq_o, ctl_cmd_o, ctl_ba_o, ctl_adr_o},
              {1'b1, 1'b1, ACT, 3'd7, 13'h1ABC});
        @(posedge clock); #1;
      end
      ctl_rdy_i = 1'b1;
      wait_ready("stall_return_idle");
      check("stall_write_once", n_write_hs - w0, 1);
      check("stall_write_adr", last_col_adr, 13'h7FF);
    end

    // Back-to-back requests with valid held high.
    begin : b2b_test
      int a0, n, gap;
      a0 = act_cyc.size(); n = 0;
      req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = addr_a; ctl_rdy_i = 1'b1;
      while (act_cyc.size() < a0 + 2 && n < 60) begin
        @(negedge clock);
        @(posedge clock); #1;
        n++;
      end
      req_valid_i = 1'b0;
      check("b2b_two_acts", (act_cyc.size() >= a0 + 2), 1);
      gap = (act_cyc.size() >= a0 + 2) ? (act_cyc[a0+1] - act_cyc[a0]) : 0;
      if (gap < 10) $display("act spacing %0d", gap);
      check("b2b_spacing_ge10", (gap >= 10), 1);
      wait_ready("b2b_return_idle");
    end

    check("never_ref", n_ref_hs, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
